taxi_eth_frame_gen: RTL and testbench
=====================================

// Module: taxi_eth_frame_gen
// PURPOSE
//  Ethernet test-frame source driving a 64-bit MAC TX AXI-stream (taxi_axis_if, DATA_W=64).
//  It is the initiator end of the per-channel loopback path. It emits numbered frames toward
//  a port whose far end echoes RX back to TX, so traffic can be generated on a link under test.
//  One instance per MAC channel, in the MAC tx_clk domain.
// PARAMETERS
//  MAX_LEN   9000            max frame length, bytes excl. FCS; cfg_len clamped to [60, MAX_LEN]
//  ID_VAL    0               constant tid on every beat
//  ETH_TYPE  16'h88B5        ethertype in generated frames
// PORTS
//  clk               in   1      tx clock; all logic on rising edge
//  rst               in   1      asynchronous, active-high reset
//  m_axis            src  intf   taxi_axis_if.src: tdata 64, tkeep 8, tlast, tid 8, tuser 1
//  start             in   1      pulse: latch cfg_*, begin run (ignored while busy)
//  stop              in   1      pulse: finish current frame, then return to idle
//  cfg_dst_mac       in   48     destination MAC
//  cfg_src_mac       in   48     source MAC
//  cfg_len           in   16     frame length in bytes, excl. FCS
//  cfg_count         in   32     frames per run; 0 = continuous until stop
//  cfg_gap           in   16     idle cycles (tvalid=0) between frames
//  busy              out  1      run in progress
//  stat_frame_count  out  32     frames completed since last start (wraps)
//  stat_seq          out  32     sequence number of next frame
// BEHAVIOUR
//  Reset: tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, counters=0, state IDLE.
//  FSM: IDLE -start-> FRAME -last beat accepted-> GAP (cfg_gap>0) or FRAME/IDLE.
//       GAP -gap counter expires-> FRAME, or IDLE if run done or stop pending.
//  start in IDLE: latch cfg_* (len clamped); seq=0; frame_count=0; busy=1.
//  First tvalid appears the cycle after start (1-cycle latency).
//  Byte n of frame sits at tdata[8*(n%8)+:8].
//  Byte layout: 0-5 dst, 6-11 src, 12-13 ETH_TYPE, 14-17 seq, 18-19 len (all big-endian);
//  20.. payload = n[7:0].
//  Beats per frame = ceil(len/8). Last beat: tlast=1, tkeep = (len%8==0) ? 8'hFF : (1<<(len%8))-1.
//  All other beats: tkeep=8'hFF.
//  tuser=0 always; tid=ID_VAL.
//  AXI rule: once tvalid=1, tdata/tkeep/tlast are held until tready.
//  tvalid never drops mid-frame; inside a frame a beat is issued every cycle tready=1.
//  Completion: frame_count++ and seq++ on the accepted tlast beat.
//  Run ends when frame_count reaches cfg_count (cfg_count != 0); busy falls the same cycle IDLE is entered.
//  stop: sets sticky flag; current frame always completes; no new frame starts; flag clears in IDLE.
//  stop in IDLE: no effect. start and stop in the same cycle in IDLE: start wins, stop is dropped.
//  cfg_gap=0: next frame's first beat valid the cycle after tlast accepted.
//  seq wraps 0xFFFFFFFF -> 0; frame_count wraps likewise.
//  Counters are 16-bit beat, 16-bit gap, 32-bit frame.
//  Reset mid-frame aborts the frame immediately (tvalid=0); the system resets the MAC TX together with this block.
// CONFIGURATION
//  TAXI_FRAME_GEN_PRBS_EN defined:
//    payload bytes (20..) come from PRBS31 (x^31+x^28+1), 8 bits/byte, 64 bits/beat;
//    seeded to all-ones at each start, continuous across frames, advanced only on accepted beats.
//  Undefined: incrementing payload as above; no LFSR logic synthesised.
// STRUCTURE
//  Package taxi_eth_frame_gen_pkg:
//    state enum (IDLE, FRAME, GAP); header byte offsets (DST=0, SRC=6, TYPE=12, SEQ=14, LEN=18, PAY=20);
//    MIN_LEN=60; PRBS31 polynomial/seed constants.
//  Sub-module taxi_lfsr (existing): PRBS31 generator, 64-bit output, instantiated only under TAXI_FRAME_GEN_PRBS_EN.
//  Header/payload byte mux is combinational from beat counter; output register stage only.
// TESTING
//  1. len=64, count=3, gap=0, tready=1:
//     24 beats; tlast on beats 8/16/24 with tkeep=FF; seq bytes 0,1,2; busy low after beat 24.
//  2. len=61, count=1:
//     8 beats; last tkeep=8'h1F; bytes 18-19 = 00 3D; byte 20 = 8'h14.
//  3. len=20 (below min), count=1: clamped to 60; 8 beats; last tkeep=8'h0F.
//  4. Random tready 50%, len=1500, count=10:
//     data held stable while stalled; 1880 beats total; frame_count=10.
//  5. count=0, gap=5, stop during frame 4:
//     frame 4 completes; exactly 5 idle cycles between frames; busy=0; stat_frame_count=4.
//  6. Async rst asserted mid-frame with tready=1:
//     tvalid=0 immediately; after release no output until start; PRBS build: payload matches reference PRBS31 model.

Source files
------------

// File: rtl/taxi_eth_frame_gen_pkg.sv
// ============================================================================
//  Module   : taxi_eth_frame_gen_pkg
//  Brief    : Shared types and constants for the Ethernet test-frame source.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package taxi_eth_frame_gen_pkg;

    // Run-level state of the frame source
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Byte offsets of the header fields inside a generated frame
    localparam logic [15:0] OFF_DST  = 16'd0;
    localparam logic [15:0] OFF_SRC  = 16'd6;
    localparam logic [15:0] OFF_TYPE = 16'd12;
    localparam logic [15:0] OFF_SEQ  = 16'd14;
    localparam logic [15:0] OFF_LEN  = 16'd18;
    localparam logic [15:0] OFF_PAY  = 16'd20;

    // Shortest legal frame excluding FCS
    localparam logic [15:0] MIN_LEN  = 16'd60;

    // PRBS31: x^31 + x^28 + 1 (feedback taps at state bits 30 and 27)
    localparam logic [30:0] PRBS31_POLY = 31'h4800_0000;
    localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

endpackage : taxi_eth_frame_gen_pkg

`default_nettype wire

// File: rtl/taxi_eth_frame_gen_if.sv
// ============================================================================
//  Module   : taxi_axis_if
//  Brief    : AXI-stream bundle used between the frame source and the MAC TX.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface taxi_axis_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    // Stream source (drives data, observes backpressure)
    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tuser,
        input  tready
    );

    // Stream sink (observes data, drives backpressure)
    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tuser,
        output tready
    );
endinterface : taxi_axis_if

`default_nettype wire

// File: rtl/taxi_lfsr.sv
// ============================================================================
//  Module   : taxi_lfsr
//  Brief    : PRBS31 generator producing 64 fresh sequence bits per step.
//             Bit i of data_o is the i-th bit shifted out of the register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module taxi_lfsr
    import taxi_eth_frame_gen_pkg::*;
#(
    parameter logic [30:0] POLY = PRBS31_POLY,
    parameter logic [30:0] SEED = PRBS31_SEED
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load_i,   // reseed; the word presented this cycle comes from SEED
    input  wire logic        adv_i,    // consume the presented word
    output logic      [63:0] data_o
);

    logic [30:0] state_q;
    logic [30:0] state_d;

    // Unroll 64 Fibonacci shifts from the current (or freshly seeded) state
    always_comb begin : p_step
        logic [30:0] s;
        logic        nb;
        s      = load_i ? SEED : state_q;
        nb     = 1'b0;
        data_o = '0;
        for (int i = 0; i < 64; i++) begin
            nb        = ^(s & POLY);
            s         = {s[29:0], nb};
            data_o[i] = nb;
        end
        state_d = adv_i ? s : (load_i ? SEED : state_q);
    end

    // Sequence state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule : taxi_lfsr

`default_nettype wire

// File: rtl/taxi_eth_frame_gen.sv
// ============================================================================
//  Module   : taxi_eth_frame_gen
//  Brief    : Numbered Ethernet test-frame source for a 64-bit MAC TX stream.
//             Build option TAXI_FRAME_GEN_PRBS_EN selects PRBS31 payload;
//             otherwise payload byte n carries n[7:0].
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module taxi_eth_frame_gen
    import taxi_eth_frame_gen_pkg::*;
#(
    parameter int          MAX_LEN  = 9000,
    parameter logic [7:0]  ID_VAL   = 8'd0,
    parameter logic [15:0] ETH_TYPE = 16'h88B5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    taxi_axis_if.src         m_axis,
    input  wire logic        start,
    input  wire logic        stop,
    input  wire logic [47:0] cfg_dst_mac,
    input  wire logic [47:0] cfg_src_mac,
    input  wire logic [15:0] cfg_len,
    input  wire logic [31:0] cfg_count,
    input  wire logic [15:0] cfg_gap,
    output logic             busy,
    output logic      [31:0] stat_frame_count,
    output logic      [31:0] stat_seq
);

    localparam logic [15:0] c_max_len = 16'(MAX_LEN);

    state_t      state_q,     state_d;
    logic [15:0] len_q,       len_d;
    logic [15:0] last_q,      last_d;       // index of the final beat
    logic [31:0] count_q,     count_d;
    logic [15:0] gap_q,       gap_d;
    logic [47:0] dst_q,       dst_d;
    logic [47:0] src_q,       src_d;
    logic [15:0] beat_q,      beat_d;       // index of the beat held in the output register
    logic [15:0] gap_cnt_q,   gap_cnt_d;
    logic [31:0] seq_q,       seq_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        stop_q,      stop_d;
    logic        tvalid_q,    tvalid_d;
    logic [63:0] tdata_q,     tdata_d;
    logic [7:0]  tkeep_q,     tkeep_d;
    logic        tlast_q,     tlast_d;

    logic        w_in_idle;
    logic [15:0] w_len_clamp;
    logic [15:0] w_len;
    logic [47:0] w_dst;
    logic [47:0] w_src;
    logic [15:0] w_last_idx;
    logic        w_accept;
    logic        w_stop_any;
    logic [31:0] w_fc_inc;
    logic        w_run_done;
    logic        w_load;
    logic [15:0] w_load_idx;
    logic [31:0] w_load_seq;
    logic [63:0] w_beat_data;
    logic [7:0]  w_beat_keep;

`ifdef TAXI_FRAME_GEN_PRBS_EN
    logic [63:0] w_prbs_word;
    wire  logic  w_start_run = w_in_idle & start;

    taxi_lfsr #(
        .POLY (PRBS31_POLY),
        .SEED (PRBS31_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_start_run),
        .adv_i  (w_load),
        .data_o (w_prbs_word)
    );
`endif

    // Header bytes by absolute frame offset; payload byte supplied by caller
    function automatic logic [7:0] frame_byte(
        input logic [15:0] n,
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [31:0] seq,
        input logic [15:0] len,
        input logic [7:0]  pay
    );
        logic [47:0] mac;
        logic [31:0] s32;
        logic [15:0] off;
        logic [7:0]  b;
        mac = '0;
        s32 = '0;
        off = '0;
        b   = pay;
        if (n < OFF_SRC) begin
            off = n - OFF_DST;
            mac = dst << {off[2:0], 3'b000};
            b   = mac[47:40];
        end else if (n < OFF_TYPE) begin
            off = n - OFF_SRC;
            mac = src << {off[2:0], 3'b000};
            b   = mac[47:40];
        end else if (n == OFF_TYPE) begin
            b = ETH_TYPE[15:8];
        end else if (n < OFF_SEQ) begin
            b = ETH_TYPE[7:0];
        end else if (n < OFF_LEN) begin
            off = n - OFF_SEQ;
            s32 = seq << {off[1:0], 3'b000};
            b   = s32[31:24];
        end else if (n == OFF_LEN) begin
            b = len[15:8];
        end else if (n < OFF_PAY) begin
            b = len[7:0];
        end
        return b;
    endfunction

    // While idle the configuration inputs feed the first beat directly
    assign w_in_idle   = (state_q == ST_IDLE);
    assign w_len_clamp = (cfg_len < MIN_LEN)   ? MIN_LEN   :
                         (cfg_len > c_max_len) ? c_max_len : cfg_len;
    assign w_len       = w_in_idle ? w_len_clamp : len_q;
    assign w_dst       = w_in_idle ? cfg_dst_mac : dst_q;
    assign w_src       = w_in_idle ? cfg_src_mac : src_q;
    assign w_last_idx  = (w_len - 16'd1) >> 3;
    assign w_accept    = tvalid_q & m_axis.tready;
    assign w_stop_any  = stop_q | stop;
    assign w_fc_inc    = frame_cnt_q + 32'd1;
    assign w_run_done  = (count_q != 32'd0) && (w_fc_inc == count_q);

    // Run sequencing: decides when and which beat enters the output register
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        last_d      = last_q;
        count_d     = count_q;
        gap_d       = gap_q;
        dst_d       = dst_q;
        src_d       = src_q;
        gap_cnt_d   = gap_cnt_q;
        seq_d       = seq_q;
        frame_cnt_d = frame_cnt_q;
        stop_d      = stop_q;
        w_load      = 1'b0;
        w_load_idx  = '0;
        w_load_seq  = seq_q;
        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    len_d       = w_len_clamp;
                    last_d      = w_last_idx;
                    count_d     = cfg_count;
                    gap_d       = cfg_gap;
                    dst_d       = cfg_dst_mac;
                    src_d       = cfg_src_mac;
                    seq_d       = '0;
                    frame_cnt_d = '0;
                    w_load      = 1'b1;
                    w_load_seq  = '0;
                    state_d     = ST_FRAME;
                end
            end
            ST_FRAME: begin
                stop_d = w_stop_any;
                if (w_accept) begin
                    if (beat_q != last_q) begin
                        w_load     = 1'b1;
                        w_load_idx = beat_q + 16'd1;
                    end else begin
                        frame_cnt_d = w_fc_inc;
                        seq_d       = seq_q + 32'd1;
                        if (w_run_done || w_stop_any) begin
                            state_d = ST_IDLE;
                        end else if (gap_q != 16'd0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end else begin
                            w_load     = 1'b1;
                            w_load_seq = seq_q + 32'd1;
                        end
                    end
                end
            end
            ST_GAP: begin
                stop_d = w_stop_any;
                if (gap_cnt_q <= 16'd1) begin
                    if (w_stop_any) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FRAME;
                        w_load  = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte lanes of the beat being loaded, masked beyond the frame end
    always_comb begin : p_beat
        logic [15:0] n;
        logic [7:0]  pay;
        n           = '0;
        pay         = '0;
        w_beat_data = '0;
        w_beat_keep = '0;
        for (int k = 0; k < 8; k++) begin
            n = {w_load_idx[12:0], 3'(k)};
`ifdef TAXI_FRAME_GEN_PRBS_EN
            pay = w_prbs_word[8*k +: 8];
`else
            pay = n[7:0];
`endif
            if (n < w_len) begin
                w_beat_keep[k]       = 1'b1;
                w_beat_data[8*k +: 8] = frame_byte(n, w_dst, w_src, w_load_seq, w_len, pay);
            end
        end
    end

    // Output register: load a new beat, or clear once the last one is taken
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        beat_d   = beat_q;
        if (w_load) begin
            tvalid_d = 1'b1;
            tdata_d  = w_beat_data;
            tkeep_d  = w_beat_keep;
            tlast_d  = (w_load_idx == w_last_idx);
            beat_d   = w_load_idx;
        end else if (w_accept) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            last_q      <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            seq_q       <= '0;
            frame_cnt_q <= '0;
            stop_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            last_q      <= last_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            seq_q       <= seq_d;
            frame_cnt_q <= frame_cnt_d;
            stop_q      <= stop_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
        end
    end

    assign m_axis.tvalid    = tvalid_q;
    assign m_axis.tdata     = tdata_q;
    assign m_axis.tkeep     = tkeep_q;
    assign m_axis.tlast     = tlast_q;
    assign m_axis.tid       = ID_VAL;
    assign m_axis.tuser     = 1'b0;
    assign busy             = (state_q != ST_IDLE);
    assign stat_frame_count = frame_cnt_q;
    assign stat_seq         = seq_q;

endmodule : taxi_eth_frame_gen

`default_nettype wire

// File: tb/tb_taxi_eth_frame_gen.sv
// ============================================================================
//  Module   : tb_taxi_eth_frame_gen
//  Brief    : Self-checking bench for taxi_eth_frame_gen against a frame-level
//             reference model (byte layout, beat count, gaps, run control).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_taxi_eth_frame_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [47:0] cfg_dst_mac = '0;
    logic [47:0] cfg_src_mac = '0;
    logic [15:0] cfg_len = '0;
    logic [31:0] cfg_count = '0;
    logic [15:0] cfg_gap = '0;
    logic        busy;
    logic [31:0] stat_frame_count;
    logic [31:0] stat_seq;

    int n_checks = 0;
    int n_err    = 0;

    logic [30:0] ref_lfsr = '1;

    taxi_axis_if #(.DATA_W(64)) axis ();

    taxi_eth_frame_gen #(
        .MAX_LEN  (9000),
        .ID_VAL   (8'd0),
        .ETH_TYPE (16'h88B5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .m_axis           (axis),
        .start            (start),
        .stop             (stop),
        .cfg_dst_mac      (cfg_dst_mac),
        .cfg_src_mac      (cfg_src_mac),
        .cfg_len          (cfg_len),
        .cfg_count        (cfg_count),
        .cfg_gap          (cfg_gap),
        .busy             (busy),
        .stat_frame_count (stat_frame_count),
        .stat_seq         (stat_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference PRBS31 as a plain bit stream: next 64 bits, first bit in bit 0
    task automatic prbs_next(output logic [63:0] w);
        logic nb;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            nb       = ref_lfsr[30] ^ ref_lfsr[27];
            ref_lfsr = {ref_lfsr[29:0], nb};
            w[i]     = nb;
        end
    endtask

    // Expected byte n of frame number seq
    function automatic logic [7:0] exp_byte(input int seq, input int n, input int len,
                                            input logic [47:0] dst, input logic [47:0] src,
                                            input logic [63:0] pw);
        logic [159:0] hdr;
        hdr = {dst, src, 16'h88B5, 32'(seq), 16'(len)};
        if (n < 20) return hdr[8*(19-n) +: 8];
`ifdef TAXI_FRAME_GEN_PRBS_EN
        return pw[8*(n%8) +: 8];
`else
        if (pw == 64'h1) return 8'h00;  // never true in this build; keeps pw referenced
        return 8'(n);
`endif
    endfunction

    // One run: start, follow every beat against the model, check run end
    task automatic run(input int len_cfg, input int cnt, input int gap, input int rdy_pct,
                       input int stop_frame, input bit stop_with_start);
        logic [47:0] dst, src;
        logic [63:0] exp_d, mask, pw, hd;
        logic [7:0]  exp_k, hk;
        logic        hl;
        int len, nbeats, frames_exp, frame, beat, idle, cyc, total, n;
        bit in_gap, held, done, stop_sent, rdy;

        dst = {16'($urandom), $urandom};
        src = {16'($urandom), $urandom};
        len = (len_cfg < 60) ? 60 : ((len_cfg > 9000) ? 9000 : len_cfg);
        nbeats = (len + 7) / 8;
        frames_exp = (cnt != 0) ? cnt : stop_frame + 1;
        frame = 0; beat = 0; idle = 0; cyc = 0; total = 0;
        in_gap = 0; held = 0; done = 0; stop_sent = 0;
        hd = '0; hk = '0; hl = 0; pw = '0;

        @(negedge clk);
        cfg_dst_mac = dst; cfg_src_mac = src; cfg_len = 16'(len_cfg);
        cfg_count = 32'(cnt); cfg_gap = 16'(gap);
        start = 1'b1; stop = stop_with_start;
        axis.tready = ($urandom_range(99) < rdy_pct);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("first_valid", axis.tvalid, 1);
        chk("busy_run", busy, 1);
        chk("fc_restart", stat_frame_count, 0);
        ref_lfsr = '1;
        prbs_next(pw);

        while (!done && cyc < 30000) begin
            if (axis.tvalid) begin
                if (in_gap) chk("gap_cycles", idle, gap);
                in_gap = 0;
                if (held) begin
                    chk("hold_data", axis.tdata, hd);
                    chk("hold_keep", axis.tkeep, hk);
                    chk("hold_last", axis.tlast, hl);
                end
                exp_d = '0; exp_k = '0; mask = '0;
                for (int k = 0; k < 8; k++) begin
                    n = beat * 8 + k;
                    if (n < len) begin
                        exp_k[k] = 1'b1;
                        mask[8*k +: 8] = 8'hFF;
                        exp_d[8*k +: 8] = exp_byte(frame, n, len, dst, src, pw);
                    end
                end
                chk("tdata", axis.tdata & mask, exp_d);
                chk("tkeep", axis.tkeep, exp_k);
                chk("tlast", axis.tlast, (beat == nbeats - 1));
                chk("tid_tuser", {axis.tid, axis.tuser}, 9'd0);
            end else begin
                if (held || beat != 0) chk("valid_in_frame", axis.tvalid, 1);
                if (in_gap) idle++;
            end
            rdy = ($urandom_range(99) < rdy_pct);
            axis.tready = rdy;
            stop = 1'b0;
            if (stop_frame >= 0 && frame == stop_frame && beat == 2 && axis.tvalid && !stop_sent) begin
                stop = 1'b1;
                stop_sent = 1;
            end
            if (axis.tvalid && rdy) begin
                held = 0;
                total++;
                prbs_next(pw);
                beat++;
                if (beat == nbeats) begin
                    beat = 0; frame++; in_gap = 1; idle = 0;
                    if (frame == frames_exp) done = 1;
                end
            end else if (axis.tvalid) begin
                held = 1; hd = axis.tdata; hk = axis.tkeep; hl = axis.tlast;
            end
            @(negedge clk);
            cyc++;
        end
        stop = 1'b0;
        axis.tready = 1'b1;
        if (!done) chk("run_timeout", 0, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", axis.tvalid, 0);
        chk("frame_count", stat_frame_count, frames_exp);
        chk("stat_seq", stat_seq, frames_exp);
        chk("beats_total", total, nbeats * frames_exp);
        repeat (gap + 3) @(negedge clk);
        chk("quiet_after", axis.tvalid, 0);
    endtask

    initial begin
        axis.tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_tkeep", axis.tkeep, 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_counts", {stat_frame_count, stat_seq}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(64,   3,  0, 100, -1, 0);   // 24 beats, full last keep
        run(61,   1,  0, 100, -1, 0);   // last keep 1F
        run(20,   1,  0, 100, -1, 0);   // clamped up to 60
        run(1500, 10, 0, 50,  -1, 0);   // random backpressure, 1880 beats
        run(100,  0,  5, 100,  3, 0);   // continuous, stop in 4th frame
        run(60,   2,  1, 80,  -1, 1);   // start wins over simultaneous stop
        run(65535, 1, 0, 100, -1, 0);   // clamped down to MAX_LEN
        for (int i = 0; i < 4; i++)
            run(int'($urandom_range(1, 300)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), 60, -1, 0);

        // Asynchronous reset in the middle of a continuous run
        @(negedge clk);
        cfg_len = 16'd200; cfg_count = '0; cfg_gap = '0;
        axis.tready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", axis.tvalid, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_valid", axis.tvalid, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        stop = 1'b1;                    // stop while idle has no lasting effect
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_valid", axis.tvalid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_fc", stat_frame_count, 0);
        run(120, 2, 2, 70, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_taxi_eth_frame_gen

`default_nettype wire
